// File: rtl/psum_ofifo.sv
// Output-side psum collector: one FIFO per array column absorbs the skewed drain,
// and a full de-skewed row is popped from all columns at once.
module psum_ofifo #(
   parameter int psum_bw   = 16,
   parameter int col       = 8,
   parameter int depth_log = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic [col-1:0]         o_overflow
);

   localparam int depth = 1 << depth_log;
   localparam logic [depth_log:0] ptr_one = {{depth_log{1'b0}}, 1'b1};

   logic [psum_bw-1:0]     mem_q [col][depth];
   logic [depth_log:0]     wptr_q [col];
   logic [depth_log:0]     wptr_d [col];
   logic [depth_log:0]     rptr_q [col];
   logic [depth_log:0]     rptr_d [col];
   logic [psum_bw*col-1:0] out_q, out_d;
   logic [col-1:0]         ovf_q, ovf_d;
   logic [col-1:0]         empty_s, full_s, wr_acc_s;
   logic                   valid_s, rd_acc_s;

   // Per-column status and write/read acceptance from the registered pointers
   always_comb begin
      empty_s  = '0;
      full_s   = '0;
      wr_acc_s = '0;
      for (int c = 0; c < col; c++) begin
         empty_s[c]  = (wptr_q[c] == rptr_q[c]);
         full_s[c]   = (wptr_q[c][depth_log-1:0] == rptr_q[c][depth_log-1:0]) &&
                       (wptr_q[c][depth_log] != rptr_q[c][depth_log]);
         wr_acc_s[c] = wr[c] && !full_s[c];
      end
      valid_s  = &(~empty_s);
      rd_acc_s = rd && valid_s;
   end

   // Next-state pointers, output row and sticky overflow flags
   always_comb begin
      out_d = out_q;
      ovf_d = ovf_q;
      for (int c = 0; c < col; c++) begin
         wptr_d[c] = wptr_q[c];
         rptr_d[c] = rptr_q[c];
         if (wr_acc_s[c]) begin
            wptr_d[c] = wptr_q[c] + ptr_one;
         end else begin
            wptr_d[c] = wptr_q[c];
         end
         // Columns are popped only as a whole row so they stay aligned
         if (rd_acc_s) begin
            rptr_d[c] = rptr_q[c] + ptr_one;
            out_d[c*psum_bw +: psum_bw] = mem_q[c][rptr_q[c][depth_log-1:0]];
         end else begin
            rptr_d[c] = rptr_q[c];
         end
         ovf_d[c] = ovf_q[c] | (wr[c] & full_s[c]);
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < col; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
         end
         out_q <= '0;
         ovf_q <= '0;
      end else begin
         for (int c = 0; c < col; c++) begin
            wptr_q[c] <= wptr_d[c];
            rptr_q[c] <= rptr_d[c];
         end
         out_q <= out_d;
         ovf_q <= ovf_d;
      end
   end

   // Storage is not reset; pointer reset makes old entries unreachable
   always_ff @(posedge clk) begin
      for (int c = 0; c < col; c++) begin
         if (!reset && wr_acc_s[c]) begin
            mem_q[c][wptr_q[c][depth_log-1:0]] <= in[c*psum_bw +: psum_bw];
         end
      end
   end

   assign out        = out_q;
   assign o_valid    = valid_s;
   assign o_full     = |full_s;
   assign o_ready    = ~(|full_s);
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed self-checking bench for psum_ofifo: reset, skewed drain, partial
// columns, fill/overflow, streaming across pointer wrap and reads when empty.
module tb_psum_ofifo;

   localparam int BW  = 16;
   localparam int COL = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [BW*COL-1:0] in;
   logic [COL-1:0]    wr;
   logic              rd;
   logic [BW*COL-1:0] out;
   logic              o_valid, o_full, o_ready;
   logic [COL-1:0]    o_overflow;

   int n_cmp = 0;
   int n_err = 0;

   psum_ofifo #(.psum_bw(BW), .col(COL), .depth_log(4)) dut (
      .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
      .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
      .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [BW*COL-1:0] row(input logic [15:0] base);
      logic [BW*COL-1:0] r;
      for (int c = 0; c < COL; c++) r[c*BW +: BW] = base + 16'(c);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [BW*COL-1:0] row_a, skew_row;

   initial begin
      reset = 1'b1; in = '0; wr = '0; rd = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_out", out, 128'h0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_full", o_full, 1'b0);
      chk("rst_ready", o_ready, 1'b1);
      chk("rst_ovf", o_overflow, 8'h00);

      // reset mid-stream after 5 resident rows; wr/rd ignored on reset edge
      wr = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         in = row(16'h1000 + 16'(i * 16));
         tick();
      end
      wr = '0; rd = 1'b1;
      tick();
      chk("mid_out0", out, row(16'h1000));
      reset = 1'b1; wr = 8'hFF; in = row(16'hAAA0);
      tick();
      reset = 1'b0; wr = '0; rd = 1'b0;
      chk("mid_rst_out", out, 128'h0);
      chk("mid_rst_valid", o_valid, 1'b0);
      chk("mid_rst_ready", o_ready, 1'b1);
      chk("mid_rst_ovf", o_overflow, 8'h00);
      row_a = row(16'h5550);
      in = row_a; wr = 8'hFF;
      tick();
      wr = '0;
      chk("post_rst_valid", o_valid, 1'b1);
      rd = 1'b1;
      tick();
      chk("post_rst_out", out, row_a);
      chk("post_rst_empty", o_valid, 1'b0);

      // skewed drain with rd held high
      skew_row = row(16'h0100);
      in = skew_row;
      for (int c = 0; c < COL; c++) begin
         wr = 8'h01 << c;
         tick();
         if (c < COL - 1) chk("skew_valid_low", o_valid, 1'b0);
      end
      wr = '0;
      chk("skew_valid_rise", o_valid, 1'b1);
      chk("skew_out_hold", out, row_a);
      tick();
      chk("skew_out", out, skew_row);
      chk("skew_valid_fall", o_valid, 1'b0);

      // partial columns: 0..6 only, then column 7
      in = row(16'h2000); wr = 8'h7F;
      tick();
      wr = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("part_valid", o_valid, 1'b0);
         chk("part_out_hold", out, skew_row);
      end
      wr = 8'h80;
      tick();
      wr = '0;
      chk("part_valid_rise", o_valid, 1'b1);
      tick();
      chk("part_out", out, row(16'h2000));
      chk("part_one_read", o_valid, 1'b0);
      tick();
      chk("part_out_hold2", out, row(16'h2000));
      rd = 1'b0;

      // fill to 16 entries, then overflow column 0
      wr = 8'hFF;
      for (int i = 0; i < 16; i++) begin
         in = row(16'h3000 + 16'(i * 16));
         tick();
         if (i == 14) chk("fill15_full", o_full, 1'b0);
      end
      chk("fill_full", o_full, 1'b1);
      chk("fill_ready", o_ready, 1'b0);
      chk("fill_valid", o_valid, 1'b1);
      in = row(16'hBEE0); wr = 8'h01;
      tick();
      wr = '0;
      chk("ovf_flag", o_overflow, 8'h01);
      chk("ovf_still_full", o_full, 1'b1);
      rd = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("drain_out", out, row(16'h3000 + 16'(i * 16)));
         if (i == 0) chk("drain_ready", o_ready, 1'b1);
      end
      chk("drain_empty", o_valid, 1'b0);
      rd = 1'b0;

      // 8 resident rows, then 40 cycles of simultaneous write and read
      wr = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         in = row(16'h4000 + 16'(i * 16));
         tick();
      end
      rd = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in = row(16'h4000 + 16'((i + 8) * 16));
         tick();
         chk("wrap_out", out, row(16'h4000 + 16'(i * 16)));
         chk("wrap_valid", o_valid, 1'b1);
         chk("wrap_full", o_full, 1'b0);
      end
      wr = '0;
      chk("wrap_ovf", o_overflow, 8'h01);
      for (int i = 40; i < 48; i++) begin
         tick();
         chk("wrap_tail", out, row(16'h4000 + 16'(i * 16)));
      end
      chk("wrap_occ_empty", o_valid, 1'b0);

      // read while empty
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("empty_rd_out", out, row(16'h4000 + 16'(47 * 16)));
         chk("empty_rd_valid", o_valid, 1'b0);
      end
      rd = 1'b0;
      in = row(16'h6000); wr = 8'hFF;
      tick();
      wr = '0; rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("empty_rd_ptrs", out, row(16'h6000));
      chk("empty_rd_final", o_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
